// File: rtl/bif_bus_watchdog_if.sv
// Handshake bundle between the BIF bus-cycle driver and the
// watchdog that times out hung BCTL cycles.
interface bif_bus_watchdog_if #(
    parameter int CNT_W = 12
);
    logic             BAPR_n;
    logic             BDAP_n;
    logic             BDRY_n;
    logic             BERROR_n;
    logic             CLEAR_n;
    logic             STAT_CLR;
    logic             TOUT;
    logic             BUSY;
    logic [3:0]       STAT;
    logic [CNT_W-1:0] LAST_LAT;

    modport master (
        output BAPR_n, BDAP_n, BDRY_n, BERROR_n,
        output CLEAR_n, STAT_CLR,
        input  TOUT, BUSY, STAT, LAST_LAT
    );

    modport slave (
        input  BAPR_n, BDAP_n, BDRY_n, BERROR_n,
        input  CLEAR_n, STAT_CLR,
        output TOUT, BUSY, STAT, LAST_LAT
    );
endinterface

// File: rtl/bif_bus_watchdog.sv
// Bus cycle monitor: raises TOUT on hung BIF cycles, keeps sticky
// error status and the latency of the last completed cycle.
module bif_bus_watchdog #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd640,
    parameter int          CNT_W          = 12
) (
    input  logic              sysclk,
    input  logic              sys_rst,
    bif_bus_watchdog_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_TOUT
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(TIMEOUT_CYCLES - 16'd1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic [3:0]       stat_q, stat_d;
    logic             tout_q, tout_d;
    logic             busy_q, busy_d;

    logic [2:0]       ev;
    logic [CNT_W-1:0] cnt_inc;
    logic             cmpl;
    logic             rel;
    logic             tmo;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign cmpl    = !bus.BDRY_n || !bus.BERROR_n;
    assign rel     = bus.BAPR_n && bus.BDAP_n;
    assign tmo     = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        tout_d  = tout_q;
        busy_d  = busy_q;
        ev      = 3'b000;

        unique case (state_q)
            S_IDLE: begin
                ev[2] = !bus.BDRY_n;
                if (!bus.BAPR_n) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_ADDR: begin
                if (!bus.BDAP_n) begin
                    if (cmpl) begin
                        state_d = S_DONE;
                        lat_d   = cnt_inc;
                        ev[1]   = !bus.BERROR_n;
                    end else if (tmo) begin
                        state_d = S_TOUT;
                        tout_d  = 1'b1;
                        ev[0]   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    ev[2] = !bus.BDRY_n;
                    // Address withdrawn: abandon quietly
                    if (bus.BAPR_n) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else if (tmo) begin
                        state_d = S_TOUT;
                        tout_d  = 1'b1;
                        ev[0]   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_DATA: begin
                if (cmpl) begin
                    state_d = S_DONE;
                    lat_d   = cnt_inc;
                    ev[1]   = !bus.BERROR_n;
                end else if (tmo) begin
                    state_d = S_TOUT;
                    tout_d  = 1'b1;
                    ev[0]   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                if (rel) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_TOUT: begin
                ev[2] = !bus.BDRY_n;
                if (rel) begin
                    state_d = S_IDLE;
                    tout_d  = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                tout_d  = 1'b0;
            end
        endcase

        // A same-edge event survives the clear; overrun needs the old bit
        if (bus.STAT_CLR) begin
            stat_d = {1'b0, ev};
        end else begin
            stat_d = {stat_q[3] | (|(ev & stat_q[2:0])),
                      stat_q[2:0] | ev};
        end

        if (!bus.CLEAR_n) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tout_d  = 1'b0;
            busy_d  = 1'b0;
            lat_d   = lat_q;
            stat_d  = stat_q;
        end
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            stat_q  <= 4'b0000;
            tout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            stat_q  <= stat_d;
            tout_q  <= tout_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.TOUT     = tout_q;
    assign bus.BUSY     = busy_q;
    assign bus.STAT     = stat_q;
    assign bus.LAST_LAT = lat_q;

endmodule

// File: tb/tb_bif_bus_watchdog.sv
// Randomized plus directed bench for bif_bus_watchdog against an
// edge-index based behavioural model.
module tb_bif_bus_watchdog;

    localparam int T = 16;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    bif_bus_watchdog_if #(.CNT_W(W)) bus ();

    bif_bus_watchdog #(
        .TIMEOUT_CYCLES(16'(T)),
        .CNT_W         (W)
    ) dut (
        .sysclk (clk),
        .sys_rst(rst),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: a cycle is described by the edge index it started on
    bit         m_act;
    bit         m_data;
    bit         m_done;
    bit         m_to;
    int         m_start;
    int         m_edge = 0;
    logic [3:0] m_stat;
    int         m_lat;

    function automatic void chk(input string nm,
                                input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic void model_edge();
        logic [2:0] ev;
        int         k;
        bit         in_data;
        ev = 3'b000;
        if (rst) begin
            m_act  = 0;
            m_data = 0;
            m_done = 0;
            m_to   = 0;
            m_stat = 4'b0000;
            m_lat  = 0;
        end else if (!bus.CLEAR_n) begin
            m_act  = 0;
            m_data = 0;
            m_done = 0;
            m_to   = 0;
        end else begin
            k = m_edge - m_start;
            if (!m_act) begin
                if (!bus.BDRY_n) ev[2] = 1'b1;
                if (!bus.BAPR_n) begin
                    m_act   = 1;
                    m_start = m_edge;
                    m_data  = 0;
                    m_done  = 0;
                    m_to    = 0;
                end
            end else if (m_to) begin
                if (!bus.BDRY_n) ev[2] = 1'b1;
                if (bus.BAPR_n && bus.BDAP_n) begin
                    m_act = 0;
                    m_to  = 0;
                end
            end else if (m_done) begin
                if (bus.BAPR_n && bus.BDAP_n) begin
                    m_act  = 0;
                    m_done = 0;
                end
            end else begin
                in_data = m_data || !bus.BDAP_n;
                if (!in_data && !bus.BDRY_n) ev[2] = 1'b1;
                if (!in_data && bus.BAPR_n) begin
                    m_act = 0;
                end else if (in_data &&
                             (!bus.BDRY_n || !bus.BERROR_n)) begin
                    m_done = 1;
                    m_lat  = k;
                    if (!bus.BERROR_n) ev[1] = 1'b1;
                end else begin
                    m_data = in_data;
                    if (k == T) begin
                        m_to  = 1;
                        ev[0] = 1'b1;
                    end
                end
            end
            if (bus.STAT_CLR) begin
                m_stat = {1'b0, ev};
            end else begin
                m_stat[3]   = m_stat[3] | (|(ev & m_stat[2:0]));
                m_stat[2:0] = m_stat[2:0] | ev;
            end
        end
        m_edge++;
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("TOUT", 32'(bus.TOUT), 32'(m_to));
            chk("BUSY", 32'(bus.BUSY), 32'(m_act));
            chk("STAT", 32'(bus.STAT), 32'(m_stat));
            chk("LAST_LAT", 32'(bus.LAST_LAT), 32'(m_lat));
        end
    end

    task automatic step(input logic a, input logic d,
                        input logic r, input logic er,
                        input logic cn, input logic sc,
                        input logic rs);
        @(negedge clk);
        bus.BAPR_n   = a;
        bus.BDAP_n   = d;
        bus.BDRY_n   = r;
        bus.BERROR_n = er;
        bus.CLEAR_n  = cn;
        bus.STAT_CLR = sc;
        rst          = rs;
        @(posedge clk);
        model_edge();
    endtask

    task automatic bs(input logic a, input logic d,
                      input logic r, input logic er);
        step(a, d, r, er, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lit(input string nm,
                       input logic [31:0] act_sel,
                       input logic [31:0] exp);
        logic [31:0] v;
        #1;
        unique case (act_sel)
            0:       v = 32'(bus.TOUT);
            1:       v = 32'(bus.BUSY);
            2:       v = 32'(bus.STAT);
            default: v = 32'(bus.LAST_LAT);
        endcase
        chk(nm, v, exp);
    endtask

    localparam int L_TOUT = 0;
    localparam int L_BUSY = 1;
    localparam int L_STAT = 2;
    localparam int L_LAT  = 3;

    initial begin
        int len;
        int mode;
        int rp;
        logic a;
        logic d;
        bus.BAPR_n   = 1'b1;
        bus.BDAP_n   = 1'b1;
        bus.BDRY_n   = 1'b1;
        bus.BERROR_n = 1'b1;
        bus.CLEAR_n  = 1'b1;
        bus.STAT_CLR = 1'b0;

        step(1, 1, 1, 1, 1, 0, 1);
        cmp_en = 1'b1;
        step(1, 1, 1, 1, 1, 0, 1);
        lit("rst_tout", L_TOUT, 0);
        lit("rst_busy", L_BUSY, 0);
        lit("rst_stat", L_STAT, 0);
        lit("rst_lat", L_LAT, 0);
        bs(1, 1, 1, 1);

        // normal read: data ready five edges after start
        bs(0, 1, 1, 1);
        bs(0, 1, 1, 1);
        repeat (3) bs(0, 0, 1, 1);
        bs(0, 0, 0, 1);
        lit("norm_busy", L_BUSY, 1);
        bs(0, 0, 1, 1);
        bs(1, 1, 1, 1);
        lit("norm_lat", L_LAT, 5);
        lit("norm_stat", L_STAT, 0);
        lit("norm_idle", L_BUSY, 0);

        // hung cycle
        bs(0, 1, 1, 1);
        repeat (15) bs(0, 0, 1, 1);
        lit("hung_pre", L_TOUT, 0);
        bs(0, 0, 1, 1);
        lit("hung_tout", L_TOUT, 1);
        lit("hung_stat", L_STAT, 1);
        bs(1, 1, 1, 1);
        lit("hung_rel", L_TOUT, 0);
        lit("hung_lat", L_LAT, 5);
        step(1, 1, 1, 1, 1, 1, 0);
        lit("clr_stat", L_STAT, 0);

        // completion on the timeout edge
        bs(0, 1, 1, 1);
        repeat (15) bs(0, 0, 1, 1);
        bs(0, 0, 0, 1);
        lit("edge_tout", L_TOUT, 0);
        bs(1, 1, 1, 1);
        lit("edge_lat", L_LAT, 16);
        lit("edge_stat", L_STAT, 0);

        // ready and error together, twice, then clear
        repeat (2) begin
            bs(0, 1, 1, 1);
            repeat (4) bs(0, 0, 1, 1);
            bs(0, 0, 0, 0);
            bs(1, 1, 1, 1);
        end
        lit("berr_lat", L_LAT, 5);
        lit("berr_ovr", L_STAT, 4'b1010);
        step(1, 1, 1, 1, 1, 1, 0);
        lit("berr_clr", L_STAT, 0);

        // stray ready in idle
        bs(1, 1, 0, 1);
        lit("proto", L_STAT, 4'b0100);
        step(1, 1, 0, 1, 1, 1, 0);
        lit("proto_clr", L_STAT, 4'b0100);
        step(1, 1, 1, 1, 1, 1, 0);

        // master clear during timeout, then reset
        bs(0, 1, 1, 1);
        repeat (16) bs(0, 0, 1, 1);
        lit("mc_pre", L_TOUT, 1);
        step(0, 0, 1, 1, 0, 0, 0);
        lit("mc_tout", L_TOUT, 0);
        lit("mc_busy", L_BUSY, 0);
        lit("mc_stat", L_STAT, 4'b0001);
        step(1, 1, 1, 1, 1, 0, 1);
        lit("sr_stat", L_STAT, 0);
        lit("sr_lat", L_LAT, 0);

        // randomized episodes
        repeat (400) begin
            len  = $urandom_range(1, 24);
            mode = $urandom_range(0, 3);
            rp   = ($urandom_range(0, 2) == 0) ? 0 :
                   $urandom_range(3, 20);
            repeat (len) begin
                unique case (mode)
                    0: begin a = 1; d = 1; end
                    1: begin a = 0; d = 1; end
                    2: begin a = 0; d = 0; end
                    default: begin
                        a = 1'($urandom_range(0, 1));
                        d = 1'($urandom_range(0, 1));
                    end
                endcase
                step(a, d,
                     ($urandom_range(0, 99) < rp) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
            end
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
